// File: rtl/mc_defs_pkg.sv
// Shared definitions for the multicycle MIPS control path: state encoding,
// opcodes and the datapath select codes also used by the PC generator.
package mc_defs_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTEX, S_RTWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [1:0] PCSRC_PC4  = 2'b00;
    localparam logic [1:0] PCSRC_BR   = 2'b01;
    localparam logic [1:0] PCSRC_JMP  = 2'b10;

    localparam logic [1:0] ASB_RT     = 2'b00;
    localparam logic [1:0] ASB_FOUR   = 2'b01;
    localparam logic [1:0] ASB_IMM    = 2'b10;
    localparam logic [1:0] ASB_IMM_SH = 2'b11;

    localparam logic [1:0] AOP_ADD    = 2'b00;
    localparam logic [1:0] AOP_SUB    = 2'b01;
    localparam logic [1:0] AOP_FUNCT  = 2'b10;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_BNE) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the main FSM (master) and the multicycle datapath (slave).
interface mc_control_fsm_if;

    logic [5:0] Op;
    logic       ALU_ZERO;
    logic       mem_ready;
    logic       PC_Write;
    logic [1:0] PC_Src;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       illegal_op;

    modport master (
        input  Op, ALU_ZERO, mem_ready,
        output PC_Write, PC_Src, IorD, MemRead, MemWrite, IRWrite, RegDst,
               MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal_op
    );

    modport slave (
        output Op, ALU_ZERO, mem_ready,
        input  PC_Write, PC_Src, IorD, MemRead, MemWrite, IRWrite, RegDst,
               MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal_op
    );

endinterface

// File: rtl/mc_next_state.sv
// Transition function of the main control FSM.
// MC_MEM_WAIT_EN: FETCH/MEMRD/MEMWR hold until mem_ready.
module mc_next_state
    import mc_defs_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    input  logic [5:0] op_q,
    input  logic       mem_ready,
    output state_t     next
);

    always_comb begin
        next = S_FETCH;
        case (state)
            S_FETCH:  next = S_DECODE;
            // DECODE dispatches on the live opcode; it is latched on the same edge
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:   next = S_MEMADR;
                    OP_R:           next = S_RTEX;
                    OP_ADDI:        next = S_ADDIEX;
                    OP_BEQ, OP_BNE: next = S_BRANCH;
                    OP_J:           next = S_JUMP;
                    default:        next = S_FETCH;
                endcase
            end
            S_MEMADR: next = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  next = S_MEMWB;
            S_RTEX:   next = S_RTWB;
            S_ADDIEX: next = S_ADDIWB;
            default:  next = S_FETCH;
        endcase
`ifdef MC_MEM_WAIT_EN
        if (!mem_ready && (state == S_FETCH || state == S_MEMRD || state == S_MEMWR))
            next = state;
`endif
    end

`ifndef MC_MEM_WAIT_EN
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
`endif

endmodule

// File: rtl/mc_control_fsm.sv
// Main control unit of the multicycle MIPS CPU: Moore FSM driving datapath selects.
// MC_MEM_WAIT_EN: memory states stall on mem_ready, FETCH PC/IR loads gated by it.
module mc_control_fsm
    import mc_defs_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    mc_control_fsm_if.master bus
);

    logic [STATE_W-1:0] state_q;
    logic [5:0]         op_q;
    state_t             state;
    state_t             next;
    logic               fetch_go;

    assign state = state_t'(state_q);

    mc_next_state u_next (
        .state     (state),
        .op        (bus.Op),
        .op_q      (op_q),
        .mem_ready (bus.mem_ready),
        .next      (next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATE_W'(S_FETCH);
            op_q    <= '0;
        end else begin
            state_q <= STATE_W'(next);
            if (state == S_DECODE)
                op_q <= bus.Op;
        end
    end

`ifdef MC_MEM_WAIT_EN
    assign fetch_go = bus.mem_ready;
`else
    assign fetch_go = 1'b1;
`endif

    always_comb begin
        bus.PC_Write   = 1'b0;
        bus.PC_Src     = PCSRC_PC4;
        bus.IorD       = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = ASB_RT;
        bus.ALUOp      = AOP_ADD;
        bus.illegal_op = 1'b0;
        // reset masks everything, including the FETCH strobes
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    bus.MemRead  = 1'b1;
                    bus.IRWrite  = fetch_go;
                    bus.ALUSrcB  = ASB_FOUR;
                    bus.PC_Write = fetch_go;
                end
                S_DECODE: begin
                    bus.ALUSrcB    = ASB_IMM_SH;
                    bus.illegal_op = !op_legal(bus.Op);
                end
                S_MEMADR, S_ADDIEX: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = ASB_IMM;
                end
                S_MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                end
                S_MEMWB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                end
                S_RTEX: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = AOP_FUNCT;
                end
                S_RTWB: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = 1'b1;
                end
                S_ADDIWB: bus.RegWrite = 1'b1;
                S_BRANCH: begin
                    bus.ALUSrcA  = 1'b1;
                    bus.ALUOp    = AOP_SUB;
                    bus.PC_Src   = PCSRC_BR;
                    bus.PC_Write = ((op_q == OP_BEQ) &&  bus.ALU_ZERO) ||
                                   ((op_q == OP_BNE) && !bus.ALU_ZERO);
                end
                S_JUMP: begin
                    bus.PC_Write = 1'b1;
                    bus.PC_Src   = PCSRC_JMP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm: each instruction is expanded into its
// expected per-cycle control words and compared against the DUT every cycle.
module tb_mc_control_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mc_control_fsm_if bus();

    mc_control_fsm #(.STATE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // kind: 0 plain, 1 fetch (ready-gated), 2 memory wait, 3 branch
    typedef struct {
        string       name;
        logic [15:0] v;
        int          kind;
    } step_t;

    step_t steps[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // {PC_Write, PC_Src, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
    //  RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal_op}
    function automatic logic [15:0] cv(input bit pcw, input logic [1:0] src, input bit iord,
        input bit mr, input bit mw, input bit irw, input bit rdst, input bit m2r, input bit rw,
        input bit asa, input logic [1:0] asb, input logic [1:0] aop, input bit ill);
        return {pcw, src, iord, mr, mw, irw, rdst, m2r, rw, asa, asb, aop, ill};
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b000010};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {bus.PC_Write, bus.PC_Src, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                bus.illegal_op};
    endfunction

    task automatic add(input string n, input logic [15:0] v, input int k);
        step_t s;
        s.name = n; s.v = v; s.kind = k;
        steps.push_back(s);
    endtask

    task automatic build(input logic [5:0] op);
        logic [15:0] ex_imm;
        ex_imm = cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0);
        steps.delete();
        add("fetch",  cv(1, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 0), 1);
        add("decode", cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, !legal(op)), 0);
        case (op)
            6'b100011: begin
                add("lw_adr", ex_imm, 0);
                add("lw_rd",  cv(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0), 2);
                add("lw_wb",  cv(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0), 0);
            end
            6'b101011: begin
                add("sw_adr", ex_imm, 0);
                add("sw_wr",  cv(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0), 2);
            end
            6'b000000: begin
                add("r_ex", cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0), 0);
                add("r_wb", cv(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0), 0);
            end
            6'b001000: begin
                add("addi_ex", ex_imm, 0);
                add("addi_wb", cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0), 0);
            end
            6'b000100, 6'b000101:
                add("branch", cv(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0), 3);
            6'b000010:
                add("jump", cv(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0), 0);
            default: ;
        endcase
    endtask

    // op, ALU_ZERO, Op value after DECODE, step index to assert reset at (-1 none)
    task automatic run_instr(input logic [5:0] op, input bit z, input logic [5:0] junk, input int rst_at);
        logic [15:0] exp;
        bit ready, stall;
        int s, guard;
        build(op);
        s = 0;
        guard = 0;
        while (s < steps.size()) begin
            bus.Op        = (s == 0) ? 6'($urandom) : (s == 1) ? op : junk;
            bus.ALU_ZERO  = z;
            bus.mem_ready = 1'($urandom);
            rst           = (s == rst_at);
`ifdef MC_MEM_WAIT_EN
            ready = bus.mem_ready;
`else
            ready = 1'b1;
`endif
            @(negedge clk);
            exp = steps[s].v;
            if (steps[s].kind == 1) begin
                exp[15] = ready;
                exp[9]  = ready;
            end
            if (steps[s].kind == 3)
                exp[15] = (op == 6'b000100) ? z : !z;
            if (rst) exp = '0;
            chk(rst ? "reset_mid" : steps[s].name, dut_vec(), exp);
            stall = (steps[s].kind == 1 || steps[s].kind == 2) && !ready;
            @(posedge clk); #1;
            if (rst) break;
            if (!stall) s++;
            guard++;
            if (guard > 200) begin
                chk("timeout", 16'h0001, 16'h0000);
                break;
            end
        end
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] op;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b000010};
        bus.Op = '0;
        bus.ALU_ZERO = 1'b0;
        bus.mem_ready = 1'b1;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("reset", dut_vec(), 16'h0000);
        end
        @(posedge clk); #1;

        run_instr(6'b100011, 0, 6'b000000, -1);   // LW
        run_instr(6'b000100, 1, 6'b111111, -1);   // BEQ taken
        run_instr(6'b000100, 0, 6'b000101, -1);   // BEQ not taken
        run_instr(6'b000101, 1, 6'b000100, -1);   // BNE not taken
        run_instr(6'b000101, 0, 6'b000100, -1);   // BNE taken
        run_instr(6'b000010, 0, 6'b000000, -1);   // J, Op changes afterwards
        run_instr(6'b111111, 0, 6'b000000, -1);   // illegal
        run_instr(6'b101011, 0, 6'b101011, 3);    // SW, reset during MEMWR
        run_instr(6'b000000, 0, 6'b001000, -1);
        run_instr(6'b001000, 1, 6'b000000, -1);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) op = 6'($urandom);
            else op = ops[$urandom_range(0, 6)];
            run_instr(op, 1'($urandom), 6'($urandom),
                      ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 4)) : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
